// File: rtl/sec32_pkg.sv
// Shared definitions for the 32-bit SEC encoder/corrector pair: widths, check-bit masks, word type.
package sec32_pkg;

    localparam int DW = 32;
    localparam int CW = 8;

    // c[k] = even parity of (d & CHK_MASK[k]); d[0] maps to corrector input G1.
    localparam logic [DW-1:0] CHK_MASK [CW] = '{
        32'h00FF_1111,
        32'hFF00_2222,
        32'h0F0F_4444,
        32'hF0F0_8888,
        32'h1111_00FF,
        32'h2222_FF00,
        32'h4444_0F0F,
        32'h8888_F0F0
    };

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] check;
    } sec32_word_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    function automatic logic [CW-1:0] calc_check(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        for (int k = 0; k < CW; k++) begin
            c[k] = ^(d & CHK_MASK[k]);
        end
        return c;
    endfunction

endpackage

// File: rtl/sec32_skid_buf.sv
// Two-entry valid/ready buffer: main register drives the output, skid absorbs one extra word.
module sec32_skid_buf
    import sec32_pkg::*;
#(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    buf_state_t   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         push, pop;

    // Ready depends only on the registered state, so no input-to-output ready path exists.
    assign in_ready_o  = (state_q != BUF_TWO);
    assign out_valid_o = (state_q != BUF_EMPTY);
    assign out_data_o  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        push    = in_valid_i && (state_q != BUF_TWO);
        pop     = out_ready_i && (state_q != BUF_EMPTY);
        case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    main_d  = in_data_i;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                case ({push, pop})
                    2'b11: main_d = in_data_i;
                    2'b01: state_d = BUF_EMPTY;
                    2'b10: begin
                        skid_d  = in_data_i;
                        state_d = BUF_TWO;
                    end
                    default: ;
                endcase
            end
            BUF_TWO: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/sec32_check_encoder.sv
// Check-bit encoder feeding the 32-bit SEC corrector, with one-shot bit-flip injection for bring-up.
module sec32_check_encoder
    import sec32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             inj_arm,
    input  logic [5:0]       inj_pos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [CW-1:0]    out_check,
    output logic             out_en,
    output logic             inj_pending,
    output logic [CNT_W-1:0] word_cnt
);

    logic             accept;
    logic             inj_pending_q, inj_pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW+CW-1:0] flip_vec;
    sec32_word_t      enc_word;
    sec32_word_t      out_word;

    assign accept = in_valid && in_ready;

    // The flip is applied after check generation so the corrector sees a genuine single-bit error.
    always_comb begin
        flip_vec = '0;
        if (inj_pending_q && (inj_pos < 6'd40)) begin
            flip_vec[inj_pos] = 1'b1;
        end
        enc_word.data  = in_data ^ flip_vec[DW-1:0];
        enc_word.check = calc_check(in_data) ^ flip_vec[DW+CW-1:DW];
    end

    // Consuming an armed injection wins over a coincident arm; the arm then has no effect.
    always_comb begin
        inj_pending_d = inj_pending_q;
        cnt_d         = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (accept && inj_pending_q) begin
            inj_pending_d = 1'b0;
        end else if (inj_arm) begin
            inj_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_pending_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            inj_pending_q <= inj_pending_d;
            cnt_q         <= cnt_d;
        end
    end

    sec32_skid_buf #(
        .W($bits(sec32_word_t))
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (enc_word),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_word)
    );

    assign out_data    = out_word.data;
    assign out_check   = out_word.check;
    assign out_en      = out_valid;
    assign inj_pending = inj_pending_q;
    assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_sec32_check_encoder.sv
// Bench for sec32_check_encoder: directed steps plus random traffic against a queue-based reference.
module tb_sec32_check_encoder;

    localparam int CW_T = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_data;
    logic            inj_arm;
    logic [5:0]      inj_pos;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic [7:0]      out_check;
    logic            out_en;
    logic            inj_pending;
    logic [CW_T-1:0] word_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state: expected output words in order, injection flag, accept count.
    logic [39:0] m_q[$];
    bit          m_pend;
    int          m_cnt;

    sec32_check_encoder #(.CNT_W(CW_T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .inj_arm    (inj_arm),
        .inj_pos    (inj_pos),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_check  (out_check),
        .out_en     (out_en),
        .inj_pending(inj_pending),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    // Whether data bit j participates in check bit k, written from the grouping rules.
    function automatic bit covers(int k, int j);
        if (k < 4) begin
            if (j < 16) return (j % 4) == k;
            case (k)
                0: return (j / 8) == 2;
                1: return (j / 8) == 3;
                2: return (j % 8) < 4;
                default: return (j % 8) >= 4;
            endcase
        end else begin
            if (j >= 16) return (j % 4) == (k - 4);
            case (k)
                4: return (j / 8) == 0;
                5: return (j / 8) == 1;
                6: return (j % 8) < 4;
                default: return (j % 8) >= 4;
            endcase
        end
    endfunction

    function automatic logic [7:0] model_check(logic [31:0] d);
        logic [7:0] c = 8'h00;
        for (int j = 0; j < 32; j++)
            if (d[j])
                for (int k = 0; k < 8; k++)
                    if (covers(k, j)) c[k] = ~c[k];
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [39:0] head;
        chk("out_valid", out_valid, m_q.size() > 0);
        chk("out_en", out_en, m_q.size() > 0);
        chk("in_ready", in_ready, m_q.size() < 2);
        chk("word_cnt", word_cnt, m_cnt);
        chk("inj_pending", inj_pending, m_pend);
        if (m_q.size() > 0) begin
            head = m_q[0];
            chk("out_data", out_data, head[39:8]);
            chk("out_check", out_check, head[7:0]);
        end
    endtask

    task automatic model_edge(input bit v, input logic [31:0] d, input bit arm,
                              input logic [5:0] pos, input bit ordy);
        bit          acc;
        bit          pop;
        logic [31:0] dd;
        logic [7:0]  cc;
        acc = v && (m_q.size() < 2);
        pop = ordy && (m_q.size() > 0);
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            dd = d;
            cc = model_check(d);
            if (m_pend && pos < 32) dd = dd ^ (32'h1 << pos);
            else if (m_pend && pos < 40) cc = cc ^ (8'h1 << (pos - 32));
            m_q.push_back({dd, cc});
            m_cnt = (m_cnt + 1) % (1 << CW_T);
        end
        if (acc && m_pend) m_pend = 1'b0;
        else if (arm) m_pend = 1'b1;
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit arm,
                        input logic [5:0] pos, input bit ordy);
        in_valid  = v;
        in_data   = d;
        inj_arm   = arm;
        inj_pos   = pos;
        out_ready = ordy;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge(v, d, arm, pos, ordy);
        #1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_en"}, out_en, 1'b0);
        chk({tag, "_out_data"}, out_data, 32'h0);
        chk({tag, "_out_check"}, out_check, 8'h0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_word_cnt"}, word_cnt, 0);
        chk({tag, "_inj_pending"}, inj_pending, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; inj_arm = 1'b0; inj_pos = '0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;

        // Single words and fixed patterns
        step(1, 32'h0000_0001, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("single_check", out_check, model_check(32'h1));
        step(1, 32'hFFFF_FFFF, 0, 0, 1);
        step(1, 32'h0000_FFFF, 0, 0, 1);
        step(1, 32'h8000_0000, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Backpressure: third word stalls until the consumer releases
        step(1, 32'hA5A5_0001, 0, 0, 0);
        step(1, 32'hA5A5_0002, 0, 0, 0);
        step(1, 32'hA5A5_0003, 0, 0, 0);
        step(1, 32'hA5A5_0003, 0, 0, 0);
        step(1, 32'hA5A5_0003, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Injection: data bit, check bit, out-of-range, arm coincident with accept, re-arm while pending
        step(0, 0, 1, 0, 1);
        step(1, 32'h0, 0, 6'd5, 1);
        step(0, 0, 1, 0, 1);
        step(1, 32'h0, 0, 6'd33, 1);
        step(0, 0, 1, 0, 1);
        step(1, 32'h1234_5678, 0, 6'd45, 1);
        step(1, 32'h0F0F_0F0F, 1, 6'd3, 1);
        step(0, 0, 1, 6'd3, 1);
        step(1, 32'h0F0F_0F0F, 0, 6'd39, 1);
        step(0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0,
                 6'($urandom_range(0, 63)), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

        // Async reset with buffer full clears outputs mid-cycle
        step(1, 32'hDEAD_0001, 0, 0, 0);
        step(1, 32'hDEAD_0002, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_cleared("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 32'hCAFE_F00D, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Counter wrap: 15 more accepts bring the 4-bit count back to zero
        for (int i = 0; i < 15; i++) step(1, $urandom, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("cnt_wrap", word_cnt, 0);
        step(0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
